outerprodrc_seq_ctrl: RTL and testbench

//  Run sequencer for the unary outer-product (uGEMM) array. Accepts one operand-vector pair per
//  job over a valid/ready handshake and holds it stable for the whole run. Drives the array's

---
 rtl/outerprodrc_seq_ctrl_if.sv | 43 ++++
 rtl/outerprodrc_seq_ctrl.sv | 115 +++++++++++
 tb/tb_outerprodrc_seq_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/outerprodrc_seq_ctrl_if.sv
// Request/array bus of the uGEMM run sequencer.
// The slave side is the sequencer; the master side is the job requester together with
// the array that consumes the clear/enable strobes and held operands.
// With OUTERPRODRC_SEQ_STALL_EN defined the bus also carries iStall.
interface outerprodrc_seq_ctrl_if #(
  parameter int ROWNUM   = 4,
  parameter int COLNUM   = 4,
  parameter int BITWIDTH = 8
);
  logic                         iStart;
  logic                         oReady;
  logic                         iAbort;
  logic [ROWNUM*BITWIDTH-1:0]   iData0;
  logic [COLNUM*BITWIDTH-1:0]   iData1;
  logic [ROWNUM*BITWIDTH-1:0]   oData0;
  logic [COLNUM*BITWIDTH-1:0]   oData1;
  logic                         oClr;
  logic                         oEn;
  logic                         oBitValid;
  logic                         oFirst;
  logic                         oLast;
  logic                         oDone;
  logic                         oBusy;
`ifdef OUTERPRODRC_SEQ_STALL_EN
  logic                         iStall;
`endif

  modport slave (
    input  iStart, iAbort, iData0, iData1,
`ifdef OUTERPRODRC_SEQ_STALL_EN
    input  iStall,
`endif
    output oReady, oData0, oData1, oClr, oEn, oBitValid, oFirst, oLast, oDone, oBusy
  );

  modport master (
    output iStart, iAbort, iData0, iData1,
`ifdef OUTERPRODRC_SEQ_STALL_EN
    output iStall,
`endif
    input  oReady, oData0, oData1, oClr, oEn, oBitValid, oFirst, oLast, oDone, oBusy
  );
endinterface

// File: rtl/outerprodrc_seq_ctrl.sv
// Run sequencer for the unary outer-product (uGEMM) array.
// Accepts one operand-vector pair per job, holds it for the run, pulses clear, then
// enables the array for CYCLES cycles. oBitValid/oFirst/oLast line up with the array's
// registered product bits (one cycle behind oEn).
// Optional feature: define OUTERPRODRC_SEQ_STALL_EN to add iStall, which pauses RUN.
module outerprodrc_seq_ctrl #(
  parameter int ROWNUM   = 4,
  parameter int COLNUM   = 4,
  parameter int BITWIDTH = 8,
  parameter int CYCLES   = 2**(BITWIDTH-1)
) (
  input logic                   iClk,
  input logic                   iRstN,
  outerprodrc_seq_ctrl_if.slave bus
);

  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLR   = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_LAST  = 3'd3;
  localparam logic [2:0] ST_ABORT = 3'd4;

  logic [2:0]                 state;
  logic [2:0]                 nextState;
  logic [CW-1:0]              cnt;
  logic [ROWNUM*BITWIDTH-1:0] data0Q;
  logic [COLNUM*BITWIDTH-1:0] data1Q;
  logic                       bitValidQ;
  logic                       firstQ;
  logic                       accept;
  logic                       abortTaken;
  logic                       stallRun;
  logic                       enable;

`ifdef OUTERPRODRC_SEQ_STALL_EN
  assign stallRun = bus.iStall;
`else
  assign stallRun = 1'b0;
`endif

  assign accept     = bus.iStart & (state == ST_IDLE);
  // Abort only matters once a job is in flight; in IDLE a start always wins.
  assign abortTaken = bus.iAbort &
                      ((state == ST_CLR) | (state == ST_RUN) | (state == ST_LAST));
  // A stalled RUN cycle is a bubble: no enable and the bit counter holds.
  assign enable     = (state == ST_RUN) & ~stallRun;

  // Next-state decode of the run FSM.
  always_comb begin
    // NOTE: default assignment first so every path drives nextState and no latch is inferred.
    nextState = state;
    case (state)
      ST_IDLE:  if (accept) nextState = ST_CLR;
      ST_CLR:   nextState = abortTaken ? ST_ABORT : ST_RUN;
      ST_RUN: begin
        if (abortTaken)                      nextState = ST_ABORT;
        else if (enable && cnt == CNT_LAST)  nextState = ST_LAST;
      end
      ST_LAST:  nextState = abortTaken ? ST_ABORT : ST_IDLE;
      ST_ABORT: nextState = ST_IDLE;
      default:  nextState = ST_IDLE;
    endcase
  end

  // State register and enable-cycle counter.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      // NOTE: non-blocking assignments for all clocked state so every register sees pre-edge values.
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      if (state == ST_CLR)  cnt <= '0;
      else if (enable)      cnt <= cnt + CW'(1);
    end
  end

  // Operand hold registers: loaded only on accept, kept through abort and IDLE.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      // NOTE: these are plain registers, not a memory array, so they take the async reset to 0.
      data0Q <= '0;
      data1Q <= '0;
    end else if (accept) begin
      data0Q <= bus.iData0;
      data1Q <= bus.iData1;
    end
  end

  // Product-bit strobes trail oEn by one cycle, matching the array's output register.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      bitValidQ <= 1'b0;
      firstQ    <= 1'b0;
    end else begin
      bitValidQ <= enable & ~abortTaken;
      firstQ    <= enable & ~abortTaken & (cnt == '0);
    end
  end

  assign bus.oReady    = (state == ST_IDLE);
  assign bus.oBusy     = ~bus.oReady;
  assign bus.oClr      = (state == ST_CLR) | (state == ST_ABORT);
  assign bus.oEn       = enable;
  assign bus.oBitValid = bitValidQ;
  assign bus.oFirst    = firstQ;
  assign bus.oLast     = (state == ST_LAST);
  assign bus.oDone     = (state == ST_LAST);
  assign bus.oData0    = data0Q;
  assign bus.oData1    = data1Q;

endmodule

// File: tb/tb_outerprodrc_seq_ctrl.sv
// Directed bench for outerprodrc_seq_ctrl (ROWNUM=COLNUM=2, BITWIDTH=4, CYCLES=8).
// Cycle c is the clock period after edge c-1, with the accepting edge being edge 0.
// Outputs are sampled 1 time unit after each rising edge (2 units in the stall test).
module tb_outerprodrc_seq_ctrl;

  logic iClk  = 1'b0;
  logic iRstN = 1'b0;
  int   passCnt  = 0;
  int   totalCnt = 0;

  outerprodrc_seq_ctrl_if #(.ROWNUM(2), .COLNUM(2), .BITWIDTH(4)) bus ();

  outerprodrc_seq_ctrl #(
    .ROWNUM(2), .COLNUM(2), .BITWIDTH(4), .CYCLES(8)
  ) dut (
    .iClk  (iClk),
    .iRstN (iRstN),
    .bus   (bus)
  );

  always #5 iClk = ~iClk;

  // Observed strobes: {clr, en, bitValid, first, last, done, ready, busy}
  logic [7:0] obsVec;
  assign obsVec = {bus.oClr, bus.oEn, bus.oBitValid, bus.oFirst,
                   bus.oLast, bus.oDone, bus.oReady, bus.oBusy};

  localparam logic [7:0] RESET_VEC = 8'b0000_0010;
  localparam logic [7:0] ABORT_VEC = 8'b1000_0001;

  // Expected strobes for an unstalled job, c cycles after the accepting edge.
  function automatic logic [7:0] expVec(input int c);
    logic rdy;
    rdy = (c == 0) || (c >= 11);
    return {c == 1, c >= 2 && c <= 9, c >= 3 && c <= 10, c == 3,
            c == 10, c == 10, rdy, !rdy};
  endfunction

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    totalCnt++;
    if (obsVec !== RESET_VEC) $display("FAIL reset_strobes got %b exp %b", obsVec, RESET_VEC);
    else passCnt++;
    totalCnt++;
    if ({bus.oData0, bus.oData1} !== 16'h0000)
      $display("FAIL reset_data got %h exp 0000", {bus.oData0, bus.oData1});
    else passCnt++;
    @(negedge iClk);
    iRstN = 1'b1;
    tick();
    totalCnt++;
    if (obsVec !== expVec(0)) $display("FAIL idle_after_reset got %b exp %b", obsVec, expVec(0));
    else passCnt++;
  endtask

  task automatic test_single_job();
    bus.iData0 = 8'h35;
    bus.iData1 = 8'hA7;
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      if (c > 1) tick();
      totalCnt++;
      if (obsVec !== expVec(c)) $display("FAIL single c=%0d got %b exp %b", c, obsVec, expVec(c));
      else passCnt++;
    end
    totalCnt++;
    if ({bus.oData0, bus.oData1} !== 16'h35A7)
      $display("FAIL single_data got %h exp 35a7", {bus.oData0, bus.oData1});
    else passCnt++;
  endtask

  task automatic test_back_to_back();
    int bv  = 0;
    int clr = 0;
    bus.iData0 = 8'h12;
    bus.iData1 = 8'h34;
    bus.iStart = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      tick();
      bv  += int'(bus.oBitValid);
      clr += int'(bus.oClr);
      totalCnt++;
      if (obsVec !== expVec(c % 11))
        $display("FAIL b2b c=%0d got %b exp %b", c, obsVec, expVec(c % 11));
      else passCnt++;
    end
    bus.iStart = 1'b0;
    totalCnt++;
    if (bv !== 24) $display("FAIL b2b_bitvalid_count got %0d exp 24", bv);
    else passCnt++;
    totalCnt++;
    if (clr !== 3) $display("FAIL b2b_clr_count got %0d exp 3", clr);
    else passCnt++;
  endtask

  task automatic test_busy_start();
    int done = 0;
    bus.iData0 = 8'h11;
    bus.iData1 = 8'h22;
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      if (c > 1) tick();
      bus.iStart = (c == 5);
      if (c == 5) begin
        bus.iData0 = 8'hFF;
        bus.iData1 = 8'hEE;
      end
      done += int'(bus.oDone);
      totalCnt++;
      if (obsVec !== expVec(c)) $display("FAIL busy_start c=%0d got %b exp %b", c, obsVec, expVec(c));
      else passCnt++;
    end
    bus.iStart = 1'b0;
    totalCnt++;
    if ({bus.oData0, bus.oData1} !== 16'h1122)
      $display("FAIL busy_start_data got %h exp 1122", {bus.oData0, bus.oData1});
    else passCnt++;
    totalCnt++;
    if (done !== 1) $display("FAIL busy_start_done_count got %0d exp 1", done);
    else passCnt++;
  endtask

  task automatic test_abort();
    int bv   = 0;
    int done = 0;
    bus.iData0 = 8'h44;
    bus.iData1 = 8'h55;
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) tick();
      bv   += int'(bus.oBitValid);
      done += int'(bus.oDone | bus.oLast);
      totalCnt++;
      if (obsVec !== expVec(c)) $display("FAIL abort_pre c=%0d got %b exp %b", c, obsVec, expVec(c));
      else passCnt++;
    end
    bus.iAbort = 1'b1;
    tick();
    bus.iAbort = 1'b0;
    bv   += int'(bus.oBitValid);
    done += int'(bus.oDone | bus.oLast);
    totalCnt++;
    if (obsVec !== ABORT_VEC) $display("FAIL abort_c7 got %b exp %b", obsVec, ABORT_VEC);
    else passCnt++;
    tick();
    totalCnt++;
    if (obsVec !== RESET_VEC) $display("FAIL abort_c8 got %b exp %b", obsVec, RESET_VEC);
    else passCnt++;
    totalCnt++;
    if (bv > 5 || done !== 0) $display("FAIL abort_counts got bv=%0d done=%0d exp bv<=5 done=0", bv, done);
    else passCnt++;
    totalCnt++;
    if ({bus.oData0, bus.oData1} !== 16'h4455)
      $display("FAIL abort_data got %h exp 4455", {bus.oData0, bus.oData1});
    else passCnt++;
    // Start and abort together in IDLE: the start must win.
    bus.iData0 = 8'h5A;
    bus.iData1 = 8'h3C;
    bus.iStart = 1'b1;
    bus.iAbort = 1'b1;
    tick();
    bus.iStart = 1'b0;
    bus.iAbort = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      if (c > 1) tick();
      totalCnt++;
      if (obsVec !== expVec(c)) $display("FAIL start_vs_abort c=%0d got %b exp %b", c, obsVec, expVec(c));
      else passCnt++;
    end
    totalCnt++;
    if ({bus.oData0, bus.oData1} !== 16'h5A3C)
      $display("FAIL start_vs_abort_data got %h exp 5a3c", {bus.oData0, bus.oData1});
    else passCnt++;
  endtask

  task automatic test_reset_midrun();
    int bv = 0;
    bus.iData0 = 8'h77;
    bus.iData1 = 8'h66;
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    for (int c = 2; c <= 4; c++) tick();
    iRstN = 1'b0;
    #1;
    totalCnt++;
    if (obsVec !== RESET_VEC) $display("FAIL midrun_reset got %b exp %b", obsVec, RESET_VEC);
    else passCnt++;
    totalCnt++;
    if ({bus.oData0, bus.oData1} !== 16'h0000)
      $display("FAIL midrun_reset_data got %h exp 0000", {bus.oData0, bus.oData1});
    else passCnt++;
    #1;
    iRstN = 1'b1;
    tick();
    bus.iData0 = 8'h21;
    bus.iData1 = 8'h43;
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      if (c > 1) tick();
      bv += int'(bus.oBitValid);
      totalCnt++;
      if (obsVec !== expVec(c)) $display("FAIL after_reset c=%0d got %b exp %b", c, obsVec, expVec(c));
      else passCnt++;
    end
    totalCnt++;
    if (bv !== 8) $display("FAIL after_reset_bitvalid_count got %0d exp 8", bv);
    else passCnt++;
  endtask

`ifdef OUTERPRODRC_SEQ_STALL_EN
  task automatic test_stall();
    int bv = 0;
    logic [7:0] exp;
    bus.iData0 = 8'h9C;
    bus.iData1 = 8'h3D;
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      if (c > 1) tick();
      bus.iStall = (c == 4 || c == 5);
      #1;
      exp = {c == 1,
             (c >= 2 && c <= 11) && !(c == 4 || c == 5),
             (c >= 3 && c <= 12) && !(c == 5 || c == 6),
             c == 3, c == 12, c == 12, c == 13, c != 13};
      bv += int'(bus.oBitValid);
      totalCnt++;
      if (obsVec !== exp) $display("FAIL stall c=%0d got %b exp %b", c, obsVec, exp);
      else passCnt++;
    end
    bus.iStall = 1'b0;
    totalCnt++;
    if (bv !== 8) $display("FAIL stall_bitvalid_count got %0d exp 8", bv);
    else passCnt++;
  endtask
`endif

  initial begin
    bus.iStart = 1'b0;
    bus.iAbort = 1'b0;
    bus.iData0 = '0;
    bus.iData1 = '0;
`ifdef OUTERPRODRC_SEQ_STALL_EN
    bus.iStall = 1'b0;
`endif
    test_reset();
    test_single_job();
    test_back_to_back();
    test_busy_start();
    test_abort();
    test_reset_midrun();
`ifdef OUTERPRODRC_SEQ_STALL_EN
    test_stall();
`endif
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
